// File: rtl/screen_flow_controller.sv
// -----------------------------------------------------------------------------
// screen_flow_controller
//
// Sequences the game screens: title -> countdown -> play -> (freeze after a
// lost life -> countdown again) or game over -> title.  All outputs are
// registered and reflect the state entered on the most recent clock edge.
//
// Ports
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   startOfFrame   one-cycle pulse per video frame
//   key5IsPressed  start/continue key level (only its rising edge matters)
//   lifeLost       one-cycle pulse when the ball hits the bottom border
//   life[3:0]      lives left after the current loss, valid with lifeLost
//   screenSel[1:0] 0 = title, 1 = main, 2 = game over
//   pause          freezes ball and flipper motion
//   reset_level    one-cycle pulse that re-centres ball and flipper
//   countdown[3:0] overlay digit while counting down, 0 otherwise
//   gameActive     high while counting down, playing or frozen
// -----------------------------------------------------------------------------
module screen_flow_controller #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int COUNT_SECS     = 3,
    parameter int FREEZE_FRAMES  = 90,
    parameter int OVER_FRAMES    = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       key5IsPressed,
    input  logic       lifeLost,
    input  logic [3:0] life,
    output logic [1:0] screenSel,
    output logic       pause,
    output logic       reset_level,
    output logic [3:0] countdown,
    output logic       gameActive
);

    // The frame counter must hold the largest of the three frame limits.
    localparam int MAX_A = (FRAMES_PER_SEC > FREEZE_FRAMES) ? FRAMES_PER_SEC : FREEZE_FRAMES;
    localparam int MAX_P = (MAX_A > OVER_FRAMES) ? MAX_A : OVER_FRAMES;
    localparam int CW    = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] SEC_LAST    = CW'(FRAMES_PER_SEC - 1);
    localparam logic [CW-1:0] FREEZE_LAST = CW'(FREEZE_FRAMES - 1);
    localparam logic [CW-1:0] OVER_LIMIT  = CW'(OVER_FRAMES);
    localparam logic [3:0]    COUNT_INIT  = 4'(COUNT_SECS);

    typedef enum logic [2:0] {
        ST_TITLE,
        ST_COUNT,
        ST_PLAY,
        ST_FREEZE,
        ST_OVER
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] frame_cnt_reg, frame_cnt_next;
    logic [3:0]    count_reg, count_next;
    logic          key_prev_reg;
    logic [1:0]    screen_sel_reg, screen_sel_next;
    logic          pause_reg, pause_next;
    logic          reset_level_reg, reset_level_next;
    logic          game_active_reg, game_active_next;
    logic          key_rise;

    assign key_rise = key5IsPressed & ~key_prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_TITLE;
            frame_cnt_reg   <= '0;
            count_reg       <= '0;
            key_prev_reg    <= 1'b0;
            screen_sel_reg  <= 2'd0;
            pause_reg       <= 1'b1;
            reset_level_reg <= 1'b0;
            game_active_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            frame_cnt_reg   <= frame_cnt_next;
            count_reg       <= count_next;
            key_prev_reg    <= key5IsPressed;
            screen_sel_reg  <= screen_sel_next;
            pause_reg       <= pause_next;
            reset_level_reg <= reset_level_next;
            game_active_reg <= game_active_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        frame_cnt_next   = frame_cnt_reg;
        count_next       = count_reg;
        reset_level_next = 1'b0;

        // Every transition clears the frame counter, so a frame pulse that
        // coincides with a transition is never counted in the new state.
        case (state_reg)
            ST_TITLE: begin
                if (key_rise) begin
                    state_next       = ST_COUNT;
                    frame_cnt_next   = '0;
                    count_next       = COUNT_INIT;
                    reset_level_next = 1'b1;
                end
            end
            ST_COUNT: begin
                if (startOfFrame) begin
                    if (frame_cnt_reg == SEC_LAST) begin
                        frame_cnt_next = '0;
                        count_next     = count_reg - 4'd1;
                        if (count_reg == 4'd1) begin
                            state_next = ST_PLAY;
                        end
                    end else begin
                        frame_cnt_next = frame_cnt_reg + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (lifeLost) begin
                    frame_cnt_next = '0;
                    state_next     = (life == 4'd0) ? ST_OVER : ST_FREEZE;
                end
            end
            ST_FREEZE: begin
                if (startOfFrame) begin
                    if (frame_cnt_reg == FREEZE_LAST) begin
                        state_next       = ST_COUNT;
                        frame_cnt_next   = '0;
                        count_next       = COUNT_INIT;
                        reset_level_next = 1'b1;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + 1'b1;
                    end
                end
            end
            ST_OVER: begin
                // Counter parks at the limit; reaching it unlocks the key.
                if (key_rise && (frame_cnt_reg == OVER_LIMIT)) begin
                    state_next     = ST_TITLE;
                    frame_cnt_next = '0;
                end else if (startOfFrame && (frame_cnt_reg != OVER_LIMIT)) begin
                    frame_cnt_next = frame_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next     = ST_TITLE;
                frame_cnt_next = '0;
                count_next     = '0;
            end
        endcase

        // Outputs are decoded from the upcoming state so they register
        // together with it.
        screen_sel_next  = 2'd1;
        pause_next       = 1'b1;
        game_active_next = 1'b1;
        case (state_next)
            ST_TITLE: begin
                screen_sel_next  = 2'd0;
                game_active_next = 1'b0;
            end
            ST_PLAY:  pause_next = 1'b0;
            ST_OVER: begin
                screen_sel_next  = 2'd2;
                game_active_next = 1'b0;
            end
            default: ;
        endcase
    end

    // count_reg only holds a non-zero value while in COUNT, so it doubles
    // as the registered overlay digit.
    assign screenSel   = screen_sel_reg;
    assign pause       = pause_reg;
    assign reset_level = reset_level_reg;
    assign countdown   = count_reg;
    assign gameActive  = game_active_reg;

endmodule

// File: tb/tb_screen_flow_controller.sv
module tb_screen_flow_controller;

    localparam int FPS = 2;
    localparam int CS  = 3;
    localparam int FF  = 4;
    localparam int OF  = 5;

    localparam int P_TITLE  = 0;
    localparam int P_COUNT  = 1;
    localparam int P_PLAY   = 2;
    localparam int P_FREEZE = 3;
    localparam int P_OVER   = 4;

    logic       clk;
    logic       reset;
    logic       startOfFrame;
    logic       key5IsPressed;
    logic       lifeLost;
    logic [3:0] life;
    logic [1:0] screenSel;
    logic       pause;
    logic       reset_level;
    logic [3:0] countdown;
    logic       gameActive;

    int errors = 0;
    int checks = 0;

    screen_flow_controller #(
        .FRAMES_PER_SEC(FPS),
        .COUNT_SECS    (CS),
        .FREEZE_FRAMES (FF),
        .OVER_FRAMES   (OF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .key5IsPressed(key5IsPressed),
        .lifeLost     (lifeLost),
        .life         (life),
        .screenSel    (screenSel),
        .pause        (pause),
        .reset_level  (reset_level),
        .countdown    (countdown),
        .gameActive   (gameActive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: tracks the phase and the total number of frames seen
    // since the phase began; outputs are derived arithmetically from them.
    // ---------------------------------------------------------------------
    int   m_phase;
    int   m_frames;
    logic m_prev_key;
    logic m_pulse;
    logic m_valid = 1'b0;

    always @(posedge clk) begin
        int   ph;
        int   fr;
        logic pl;
        logic rise;
        ph   = m_phase;
        fr   = m_frames;
        pl   = 1'b0;
        rise = key5IsPressed && !m_prev_key;
        if (reset) begin
            ph = P_TITLE;
            fr = 0;
            m_prev_key <= 1'b0;
            m_valid    <= 1'b1;
        end else begin
            m_prev_key <= key5IsPressed;
            case (m_phase)
                P_TITLE: if (rise) begin ph = P_COUNT; fr = 0; pl = 1'b1; end
                P_COUNT: if (startOfFrame) begin
                    fr = fr + 1;
                    if (fr == CS * FPS) begin ph = P_PLAY; fr = 0; end
                end
                P_PLAY: if (lifeLost) begin
                    ph = (life == 4'd0) ? P_OVER : P_FREEZE;
                    fr = 0;
                end
                P_FREEZE: if (startOfFrame) begin
                    fr = fr + 1;
                    if (fr == FF) begin ph = P_COUNT; fr = 0; pl = 1'b1; end
                end
                default: begin
                    if (rise && fr >= OF) begin ph = P_TITLE; fr = 0; end
                    else if (startOfFrame) fr = fr + 1;
                end
            endcase
        end
        m_phase  <= ph;
        m_frames <= fr;
        m_pulse  <= pl;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("screenSel", int'(screenSel),
                (m_phase == P_TITLE) ? 0 : (m_phase == P_OVER) ? 2 : 1);
            chk("pause", int'(pause), (m_phase == P_PLAY) ? 0 : 1);
            chk("gameActive", int'(gameActive),
                (m_phase == P_COUNT || m_phase == P_PLAY || m_phase == P_FREEZE) ? 1 : 0);
            chk("countdown", int'(countdown),
                (m_phase == P_COUNT) ? (CS - m_frames / FPS) : 0);
            chk("reset_level", int'(reset_level), int'(m_pulse));
        end
    end

    // One clock; pulses set before the call last exactly one cycle.
    task automatic step();
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        lifeLost     = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            step();
            step();
        end
    endtask

    task automatic to_play();
        key5IsPressed = 1'b1;
        step();
        key5IsPressed = 1'b0;
        frames(CS * FPS);
    endtask

    initial begin
        reset         = 1'b1;
        startOfFrame  = 1'b0;
        key5IsPressed = 1'b0;
        lifeLost      = 1'b0;
        life          = 4'd0;
        step();
        step();
        reset = 1'b0;
        $display("txn: reset released");
        chk("rst_screenSel", int'(screenSel), 0);
        chk("rst_pause", int'(pause), 1);
        chk("rst_reset_level", int'(reset_level), 0);
        chk("rst_countdown", int'(countdown), 0);
        chk("rst_gameActive", int'(gameActive), 0);

        // Key rise from TITLE, countdown 3,2,1 then PLAY.
        key5IsPressed = 1'b1;
        step();
        $display("txn: key5 rise in title");
        chk("start_pulse", int'(reset_level), 1);
        chk("start_screen", int'(screenSel), 1);
        chk("start_digit", int'(countdown), 3);
        key5IsPressed = 1'b0;
        step();
        chk("start_pulse_end", int'(reset_level), 0);
        lifeLost = 1'b1;
        life     = 4'd0;
        step();
        $display("txn: lifeLost during count");
        chk("count_ignores_loss", int'(screenSel), 1);
        frames(2);
        chk("digit_after_2", int'(countdown), 2);
        frames(2);
        chk("digit_after_4", int'(countdown), 1);
        frames(2);
        $display("txn: countdown done");
        chk("play_pause", int'(pause), 0);
        chk("play_digit", int'(countdown), 0);

        // Life lost with a coincident frame pulse -> FREEZE from frame 0.
        life         = 4'd2;
        lifeLost     = 1'b1;
        startOfFrame = 1'b1;
        step();
        $display("txn: lifeLost life=2 with frame pulse");
        chk("freeze_pause", int'(pause), 1);
        frames(FF - 1);
        chk("freeze_still", int'(reset_level), 0);
        chk("freeze_still_digit", int'(countdown), 0);
        startOfFrame = 1'b1;
        step();
        $display("txn: freeze expired");
        chk("refreeze_pulse", int'(reset_level), 1);
        chk("recount_digit", int'(countdown), 3);
        step();
        chk("refreeze_pulse_end", int'(reset_level), 0);
        frames(CS * FPS);

        // Last life lost -> OVER; key ignored early, honoured after limit.
        life     = 4'd0;
        lifeLost = 1'b1;
        step();
        $display("txn: lifeLost life=0");
        chk("over_screen", int'(screenSel), 2);
        frames(3);
        key5IsPressed = 1'b1;
        step();
        $display("txn: key5 rise at over frame 3");
        chk("over_early_key", int'(screenSel), 2);
        key5IsPressed = 1'b0;
        step();
        frames(3);
        key5IsPressed = 1'b1;
        step();
        $display("txn: key5 rise at over frame 6");
        chk("over_to_title", int'(screenSel), 0);
        step();
        step();
        chk("no_retrigger_held", int'(gameActive), 0);
        key5IsPressed = 1'b0;
        step();

        // Key held throughout: one COUNT entry, no re-trigger after OVER.
        key5IsPressed = 1'b1;
        step();
        $display("txn: key5 held from title");
        frames(CS * FPS);
        chk("held_play", int'(pause), 0);
        lifeLost = 1'b1;
        step();
        frames(OF + 1);
        $display("txn: held key in over");
        chk("held_over_stays", int'(screenSel), 2);
        key5IsPressed = 1'b0;
        step();
        key5IsPressed = 1'b1;
        step();
        chk("held_release_title", int'(screenSel), 0);
        key5IsPressed = 1'b0;
        step();

        // Reset during FREEZE frame 2 aborts without a reset_level pulse.
        to_play();
        life     = 4'd1;
        lifeLost = 1'b1;
        step();
        frames(2);
        reset = 1'b1;
        step();
        $display("txn: reset in freeze");
        chk("abort_screen", int'(screenSel), 0);
        chk("abort_pulse", int'(reset_level), 0);
        reset = 1'b0;
        step();
        chk("abort_pulse_after", int'(reset_level), 0);

        // Reset mid-COUNT.
        key5IsPressed = 1'b1;
        step();
        key5IsPressed = 1'b0;
        frames(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        $display("txn: reset in count");
        chk("abort_count_digit", int'(countdown), 0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
